// File: rtl/bd_tx_handshaker_if.sv
// rtl/bd_tx_handshaker_if.sv - Channel carrying encoded words into the BD transmitter
interface bd_tx_handshaker_if #(
    parameter int N = 21
);
    logic [N-1:0] d;
    logic         v;
    logic         a;

    modport master (output d, output v, input a);
    modport slave  (input d, input v, output a);
endinterface

// File: rtl/bd_tx_handshaker.sv
// rtl/bd_tx_handshaker.sv - 4-phase bundled-data transmitter to Braindrop; optional watchdog under BD_TX_TIMEOUT_EN
module bd_tx_handshaker #(
    parameter int N              = 21,
    parameter int SETUP_CYCLES   = 2,
    parameter int SYNC_STAGES    = 2,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic              clk,
    input  logic              reset,
    bd_tx_handshaker_if.slave BD_data_out,
    output logic [N-1:0]      bd_out_data,
    output logic              bd_out_req,
    input  logic              bd_out_ack,
    output logic              busy,
    output logic              timeout
);
    localparam int SW = (SETUP_CYCLES > 0) ? $clog2(SETUP_CYCLES + 1) : 1;

    typedef enum logic [1:0] {IDLE, SETUP, REQ_HI, REQ_LO} state_t;

    state_t                 state;
    logic [SW-1:0]          setup_cnt;
    logic [SYNC_STAGES-1:0] ack_sync;
    logic                   ack_s;

    // Bring the chip's asynchronous ack into the clk domain
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ack_sync <= '0;
        end else begin
            ack_sync <= {ack_sync[SYNC_STAGES-2:0], bd_out_ack};
        end
    end

    assign ack_s = ack_sync[SYNC_STAGES-1];

    // Ready only while idle; held low during reset so nothing is accepted then
    assign BD_data_out.a = (state == IDLE) && !reset;

    // Handshake FSM: latch word, wait setup, raise req, follow ack through 4 phases
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            setup_cnt   <= '0;
            bd_out_data <= '0;
            bd_out_req  <= 1'b0;
            busy        <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    // a is high in IDLE, so v alone marks a transfer
                    if (BD_data_out.v) begin
                        bd_out_data <= BD_data_out.d;
                        setup_cnt   <= SW'(SETUP_CYCLES);
                        busy        <= 1'b1;
                        if (SETUP_CYCLES == 0 && !ack_s) begin
                            bd_out_req <= 1'b1;
                            state      <= REQ_HI;
                        end else begin
                            state <= SETUP;
                        end
                    end
                end
                SETUP: begin
                    // Counter parks at zero while a stale ack is still high
                    if (setup_cnt == '0) begin
                        if (!ack_s) begin
                            bd_out_req <= 1'b1;
                            state      <= REQ_HI;
                        end
                    end else begin
                        setup_cnt <= setup_cnt - 1'b1;
                    end
                end
                REQ_HI: begin
                    if (ack_s) begin
                        bd_out_req <= 1'b0;
                        state      <= REQ_LO;
                    end
                end
                REQ_LO: begin
                    if (!ack_s) begin
                        busy  <= 1'b0;
                        state <= IDLE;
                    end
                end
                default: begin
                    bd_out_req <= 1'b0;
                    busy       <= 1'b0;
                    state      <= IDLE;
                end
            endcase
        end
    end

`ifdef BD_TX_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    logic [TW-1:0] to_cnt;
    logic          waiting;

    // Still waiting on the chip in the current req phase (no phase change this edge)
    assign waiting = (state == REQ_HI && !ack_s) || (state == REQ_LO && ack_s);

    // Watchdog: count cycles spent in one req phase; flag is sticky until reset
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            to_cnt  <= '0;
            timeout <= 1'b0;
        end else if (waiting) begin
            if (to_cnt != TW'(TIMEOUT_CYCLES)) begin
                to_cnt <= to_cnt + 1'b1;
            end
            if (to_cnt == TW'(TIMEOUT_CYCLES - 1)) begin
                timeout <= 1'b1;
            end
        end else begin
            to_cnt <= '0;
        end
    end
`else
    logic unused_timeout_cfg;

    assign unused_timeout_cfg = |TIMEOUT_CYCLES;
    assign timeout            = 1'b0;
`endif

endmodule

// File: tb/tb_bd_tx_handshaker.sv
// tb/tb_bd_tx_handshaker.sv - scoreboard bench for bd_tx_handshaker
`timescale 1ns/1ps
module tb_bd_tx_handshaker;
    localparam int N = 21;
`ifdef BD_TX_TIMEOUT_EN
    localparam logic TO_EN = 1'b1;
`else
    localparam logic TO_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    bd_tx_handshaker_if #(.N(N)) ch0 ();
    bd_tx_handshaker_if #(.N(N)) ch1 ();

    logic [N-1:0] data0, data1;
    logic         req0, req1, busy0, busy1, to0, to1;
    logic         ack0, ack1;
    logic         ack_model = 1'b0;
    logic         ack_man   = 1'b0;
    logic         model_en  = 1'b0;
    int           ack_delay = 0;

    assign ack0 = model_en ? ack_model : ack_man;
    assign ack1 = req1;

    bd_tx_handshaker #(.N(N), .SETUP_CYCLES(2), .SYNC_STAGES(2), .TIMEOUT_CYCLES(16)) dut0 (
        .clk(clk), .reset(reset), .BD_data_out(ch0), .bd_out_data(data0),
        .bd_out_req(req0), .bd_out_ack(ack0), .busy(busy0), .timeout(to0)
    );

    bd_tx_handshaker #(.N(N), .SETUP_CYCLES(0), .SYNC_STAGES(2), .TIMEOUT_CYCLES(1024)) dut1 (
        .clk(clk), .reset(reset), .BD_data_out(ch1), .bd_out_data(data1),
        .bd_out_req(req1), .bd_out_ack(ack1), .busy(busy1), .timeout(to1)
    );

    int n_cmp = 0;
    int n_bad = 0;
    int viol  = 0;
    logic [N-1:0] exp_q[$];
    int unsigned  xq1[$];
    logic [N-1:0] held = '0;
    logic         req_prev = 1'b0;
    logic         busy_prev = 1'b0;
    logic         busy1_prev = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic sig(input int which);
        return (which == 0) ? req0 : busy0;
    endfunction

    // Poll after each edge until the selected signal reaches val, bounded by maxc cycles
    task automatic wait_sig(input string name, input int which, input logic val, input int maxc);
        int k = 0;
        do begin
            @(posedge clk); #1;
            k++;
        end while (sig(which) !== val && k < maxc);
        if (sig(which) !== val) chk(name, 32'(sig(which)), 32'(val));
    endtask

    // Offer one word on ch0; t is the cycle count right after the transfer edge
    task automatic send0(input logic [N-1:0] w, output int unsigned t);
        int k = 0;
        t = 0;
        @(negedge clk);
        ch0.d = w;
        ch0.v = 1'b1;
        while (!ch0.a && k < 200) begin
            @(negedge clk);
            k++;
        end
        if (!ch0.a) begin
            chk("send_accept", 32'(ch0.a), 32'd1);
            ch0.v = 1'b0;
        end else begin
            exp_q.push_back(w);
            @(posedge clk); #1;
            t = cyc;
            ch0.v = 1'b0;
        end
    endtask

    // Chip model: ack follows req after ack_delay cycles in each direction
    initial begin : chip_model
        forever begin
            @(negedge clk);
            if (model_en && !reset) begin
                if (req0 && !ack_model) begin
                    repeat (ack_delay) @(negedge clk);
                    ack_model = 1'b1;
                end else if (!req0 && ack_model) begin
                    repeat (ack_delay) @(negedge clk);
                    ack_model = 1'b0;
                end
            end
        end
    end

    // Monitor: pop expected word at each req rise, watch protocol rules throughout
    initial begin : monitor
        forever begin
            @(posedge clk); #1;
            if (reset) begin
                req_prev   = 1'b0;
                busy_prev  = 1'b0;
                busy1_prev = 1'b0;
            end else begin
                if (busy0 && !busy_prev) held = data0;
                if (req0 && !req_prev) begin
                    if (ack0) viol++;
                    if (exp_q.size() == 0) chk("sb_unexpected_req", 32'd1, 32'd0);
                    else chk("sb_data", 32'(data0), 32'(exp_q.pop_front()));
                end
                if (busy0 && data0 !== held) viol++;
                if (busy0 && ch0.a) viol++;
                if (busy1 && !busy1_prev) xq1.push_back(cyc);
                req_prev   = req0;
                busy_prev  = busy0;
                busy1_prev = busy1;
            end
        end
    end

    initial begin : guard
        #600000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1);
    end

    initial begin : stim
        int unsigned t, e, k;
        logic seen;
        logic [N-1:0] w;
        ch0.d = '0; ch0.v = 1'b0;
        ch1.d = '0; ch1.v = 1'b0;

        #12;
        chk("a_during_reset", 32'(ch0.a), 32'd0);
        repeat (3) @(negedge clk);
        reset = 1'b0;
        #1;
        chk("rst_a", 32'(ch0.a), 32'd1);
        chk("rst_data", 32'(data0), 32'd0);
        chk("rst_req", 32'(req0), 32'd0);
        chk("rst_busy", 32'(busy0), 32'd0);
        chk("rst_timeout", 32'(to0), 32'd0);

        model_en = 1'b1;
        ack_delay = 3;
        send0(21'h1ABCDE, t);
        chk("single_latched", 32'(data0), 32'h1ABCDE);
        chk("single_req_low_in_setup", 32'(req0), 32'd0);
        wait_sig("single_req_rise", 0, 1'b1, 20);
        chk("single_req_latency", cyc - t, 32'd3);
        wait_sig("single_req_fall", 0, 1'b0, 30);
        chk("single_data_hold", 32'(data0), 32'h1ABCDE);
        wait_sig("single_idle", 1, 1'b0, 30);
        chk("single_sb_drained", 32'(exp_q.size()), 32'd0);

        model_en = 1'b0;
        ack_man = 1'b1;
        repeat (4) @(negedge clk);
        send0(21'h0F0F0F, t);
        seen = 1'b0;
        repeat (8) begin
            @(posedge clk); #1;
            if (req0) seen = 1'b1;
        end
        chk("stale_req_held_low", 32'(seen), 32'd0);
        chk("stale_busy", 32'(busy0), 32'd1);
        @(negedge clk);
        k = cyc;
        ack_man = 1'b0;
        wait_sig("stale_req_rise", 0, 1'b1, 20);
        chk("stale_req_latency", cyc - k, 32'd3);
        @(negedge clk); ack_man = 1'b1;
        wait_sig("stale_req_fall", 0, 1'b0, 20);
        @(negedge clk); ack_man = 1'b0;
        wait_sig("stale_idle", 1, 1'b0, 20);

        send0(21'h155555, t);
        wait_sig("to_req_rise", 0, 1'b1, 20);
        e = cyc;
        while (cyc < e + 15) begin
            @(posedge clk); #1;
        end
        chk("to_before_limit", 32'(to0), 32'd0);
        @(posedge clk); #1;
        chk("to_at_limit", 32'(to0), 32'(TO_EN));
        @(negedge clk); ack_man = 1'b1;
        wait_sig("to_req_fall", 0, 1'b0, 20);
        @(negedge clk); ack_man = 1'b0;
        wait_sig("to_idle", 1, 1'b0, 20);
        chk("to_sticky", 32'(to0), 32'(TO_EN));

        model_en = 1'b1;
        for (int i = 0; i < 100; i++) begin
            ack_delay = int'($urandom_range(0, 10));
            w = N'($urandom);
            send0(w, t);
        end
        wait_sig("stream_idle", 1, 1'b0, 100);
        chk("stream_sb_drained", 32'(exp_q.size()), 32'd0);

        @(negedge clk);
        ch1.d = 21'h0AAAAA;
        ch1.v = 1'b1;
        repeat (40) @(negedge clk);
        ch1.v = 1'b0;
        chk("s0_transfer_count_ok", 32'(xq1.size() >= 4), 32'd1);
        if (xq1.size() >= 4) begin
            for (int i = 0; i < 3; i++) chk("s0_word_period", xq1[i+1] - xq1[i], 32'd7);
        end
        chk("s0_data", 32'(data1), 32'h0AAAAA);

        ack_delay = 0;
        send0(21'h1FFFFF, t);
        @(negedge clk);
        reset = 1'b1;
        #1;
        chk("rsetup_data", 32'(data0), 32'd0);
        chk("rsetup_req", 32'(req0), 32'd0);
        chk("rsetup_busy", 32'(busy0), 32'd0);
        chk("rsetup_a_in_reset", 32'(ch0.a), 32'd0);
        exp_q.delete();
        @(negedge clk);
        reset = 1'b0;
        #1;
        chk("rsetup_a_after", 32'(ch0.a), 32'd1);

        model_en = 1'b0;
        ack_man = 1'b0;
        send0(21'h012345, t);
        wait_sig("rhi_req_rise", 0, 1'b1, 20);
        @(negedge clk);
        reset = 1'b1;
        #1;
        chk("rhi_req_async", 32'(req0), 32'd0);
        chk("rhi_data", 32'(data0), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        seen = 1'b0;
        repeat (12) begin
            @(posedge clk); #1;
            if (req0 || busy0) seen = 1'b1;
        end
        chk("rhi_no_retransmit", 32'(seen), 32'd0);
        chk("rhi_timeout_cleared", 32'(to0), 32'd0);

        chk("protocol_violations", 32'(viol), 32'd0);
        chk("final_sb_empty", 32'(exp_q.size()), 32'd0);
        chk("s0_timeout", 32'(to1), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
